// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between a master and the SRAM slave.
// Same signal set as the port-only template, grouped with master/slave views.
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic [1:0]            htrans;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hwrite;
  logic                  hready_in;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output hsel, haddr, hburst, hsize, htrans,
    output hwdata, hwrite, hready_in,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hburst, hsize, htrans,
    input  hwdata, hwrite, hready_in,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave over an internal word-addressed memory.
// Define AHB_SRAM_SLV_ERR_EN for ERROR responses on bad address/alignment.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic             hclk,
  input logic             hreset,
  ahb_sram_slave_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready, accept, err_new;
  logic                  wr_commit, rd_load;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] bitm, merged;
  logic                  unused_w;

  assign unused_w = ^{bus.hburst, bus.htrans[0], bus.haddr};

  assign ready = (state_q == S_IDLE) || (state_q == S_ERR2)
              || (state_q == S_WAIT && cnt_q == '0 && !err_q);

  // Own hready also gates acceptance so a stalled phase is never overrun.
  assign accept = bus.hsel && bus.hready_in && bus.htrans[1] && ready;

  assign wr_commit = (state_q == S_WAIT) && (cnt_q == '0)
                  && !err_q && wr_q;

`ifdef AHB_SRAM_SLV_ERR_EN
  logic [OFFW-1:0] amask;
  always_comb begin
    amask   = ~({OFFW{1'b1}} << bus.hsize);
    err_new = ((bus.haddr >> (IDXW + OFFW)) != '0)
           || (bus.hsize > 3'(OFFW))
           || ((bus.haddr[OFFW-1:0] & amask) != '0);
  end
  assign bus.hresp = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign err_new   = 1'b0;
  assign bus.hresp = 1'b0;
`endif

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      be[b] = (size_q > 3'(OFFW))
           || ((OFFW'(b) >> size_q) == (off_q >> size_q));
      bitm[8*b +: 8] = {8{be[b]}};
    end
    merged = (mem_q[idx_q] & ~bitm) | (bus.hwdata & bitm);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    wr_d    = wr_q;
    err_d   = err_q;
    if (ready) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      if (accept) begin
        idx_d   = bus.haddr[OFFW +: IDXW];
        off_d   = bus.haddr[OFFW-1:0];
        size_d  = bus.hsize;
        wr_d    = bus.hwrite;
        err_d   = err_new;
        state_d = S_WAIT;
        cnt_d   = WS;
        if (err_new) begin
          state_d = (WS == '0) ? S_ERR1 : S_WAIT;
          cnt_d   = (WS == '0) ? '0 : WS - 4'd1;
        end
      end
    end else begin
      unique case (1'b1)
        state_q == S_WAIT: begin
          if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
          else             state_d = S_ERR1;
        end
        state_q == S_ERR1: state_d = S_ERR2;
        default: ;
      endcase
    end
  end

  // Read data is fetched one edge ahead so it is valid with hready.
  assign rd_load = (state_d == S_WAIT) && (cnt_d == '0)
                && !err_d && !wr_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_load) begin
      rdata_d = (wr_commit && idx_q == idx_d) ? merged
                                              : mem_q[idx_d];
    end
    if (state_d == S_ERR1 && !wr_d) rdata_d = '0;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && wr_commit) mem_q[idx_q] <= merged;
  end

  assign bus.hrdata = rdata_q;
  assign bus.hready = ready;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench for ahb_sram_slave.
// Drives a zero-wait and a three-wait instance through one shared master.
module tb_ahb_sram_slave;
  logic clk = 1'b0;
  logic rst0, rst3;
  logic sel;

  logic        m_hsel, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic [2:0]  m_hsize, m_hburst;
  logic [1:0]  m_htrans;

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  cmd_t cq[$];
  exp_t sbq[$];

  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b0.hsel      = m_hsel & ~sel;
  assign b3.hsel      = m_hsel & sel;
  assign b0.haddr     = m_haddr;
  assign b3.haddr     = m_haddr;
  assign b0.hburst    = m_hburst;
  assign b3.hburst    = m_hburst;
  assign b0.hsize     = m_hsize;
  assign b3.hsize     = m_hsize;
  assign b0.htrans    = m_htrans;
  assign b3.htrans    = m_htrans;
  assign b0.hwdata    = m_hwdata;
  assign b3.hwdata    = m_hwdata;
  assign b0.hwrite    = m_hwrite;
  assign b3.hwrite    = m_hwrite;
  assign b0.hready_in = b0.hready;
  assign b3.hready_in = b3.hready;

  assign o_rdy   = sel ? b3.hready : b0.hready;
  assign o_resp  = sel ? b3.hresp  : b0.hresp;
  assign o_rdata = sel ? b3.hrdata : b0.hrdata;

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)
  ) u_ws0 (
    .hclk(clk), .hreset(rst0), .bus(b0)
  );

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)
  ) u_ws3 (
    .hclk(clk), .hreset(rst3), .bus(b3)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    m_hsel   = 1'b0;
    m_htrans = 2'd0;
    m_hwrite = 1'b0;
  endtask

  task automatic put_wr(logic [31:0] a, logic [2:0] sz,
                        logic [31:0] d, int w);
    cq.push_back('{1'b1, a, sz, d});
    sbq.push_back('{1'b0, 32'h0, w});
  endtask

  task automatic put_rd(logic [31:0] a, logic [31:0] exp, int w);
    cq.push_back('{1'b0, a, 3'd2, 32'h0});
    sbq.push_back('{1'b1, exp, w});
  endtask

  // Pipelined driver: address of the next beat overlaps the current data phase.
  task automatic go();
    cmd_t dp;
    exp_t e;
    bit   dp_v = 1'b0;
    bit   rdy;
    int   wcnt = 0;
    int   guard = 0;
    while ((cq.size() != 0 || dp_v) && guard < 400) begin
      guard++;
      if (cq.size() != 0) begin
        m_hsel   = 1'b1;
        m_htrans = 2'd2;
        m_haddr  = cq[0].addr;
        m_hsize  = cq[0].size;
        m_hwrite = cq[0].wr;
      end else begin
        bus_idle();
      end
      m_hwdata = dp_v ? dp.data : 32'h0;
      @(negedge clk);
      rdy = o_rdy;
      if (dp_v) begin
        if (!rdy) begin
          wcnt++;
        end else if (sbq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
          dp_v = 1'b0;
        end else begin
          e = sbq.pop_front();
          chk("waits", wcnt, e.waits);
          chk("hresp", {31'd0, o_resp}, 32'd0);
          if (e.rd) chk("rdata", o_rdata, e.data);
          wcnt = 0;
          dp_v = 1'b0;
        end
      end
      tick();
      if (rdy && cq.size() != 0) begin
        dp   = cq.pop_front();
        dp_v = 1'b1;
      end
    end
    if (guard >= 400) chk("timeout", guard, 0);
    bus_idle();
  endtask

`ifdef AHB_SRAM_SLV_ERR_EN
  task automatic err_xfer(logic wr, logic [31:0] a,
                          logic [2:0] sz, int nwait);
    int n = 0;
    m_hsel   = 1'b1;
    m_htrans = 2'd2;
    m_haddr  = a;
    m_hsize  = sz;
    m_hwrite = wr;
    tick();
    bus_idle();
    m_hwdata = 32'h0000_0077;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_resp) break;
      tick();
    end
    chk("err_waits", n, nwait);
    chk("err1_rdy", {31'd0, o_rdy}, 32'd0);
    tick();
    @(negedge clk);
    chk("err2_resp", {31'd0, o_resp}, 32'd1);
    chk("err2_rdy", {31'd0, o_rdy}, 32'd1);
    if (!wr) chk("err_rdata", o_rdata, 32'h0);
    tick();
    @(negedge clk);
    chk("post_resp", {31'd0, o_resp}, 32'd0);
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 1'b0;
    rst0     = 1'b1;
    rst3     = 1'b1;
    m_haddr  = '0;
    m_hwdata = '0;
    m_hsize  = 3'd2;
    m_hburst = 3'd1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst0_rdy",   {31'd0, b0.hready}, 32'd1);
    chk("rst0_resp",  {31'd0, b0.hresp},  32'd0);
    chk("rst0_rdata", b0.hrdata, 32'h0);
    chk("rst3_rdy",   {31'd0, b3.hready}, 32'd1);
    chk("rst3_resp",  {31'd0, b3.hresp},  32'd0);
    chk("rst3_rdata", b3.hrdata, 32'h0);
    tick();

    put_wr(32'h10, 3'd2, 32'hDEAD_BEEF, 0);
    put_rd(32'h10, 32'hDEAD_BEEF, 0);
    go();

    put_wr(32'h10, 3'd2, 32'h1122_3344, 0);
    put_wr(32'h13, 3'd0, 32'hAA00_0000, 0);
    put_rd(32'h10, 32'hAA22_3344, 0);
    put_wr(32'h20, 3'd2, 32'h0000_0005, 0);
    put_rd(32'h20, 32'h0000_0005, 0);
    go();

    put_wr(32'h30, 3'd2, 32'hCAFE_BABE, 0);
    put_wr(32'h32, 3'd1, 32'h1234_0000, 0);
    put_rd(32'h30, 32'h1234_BABE, 0);
    put_wr(32'h31, 3'd0, 32'h0000_5600, 0);
    put_rd(32'h30, 32'h1234_56BE, 0);
    put_rd(32'h10, 32'hAA22_3344, 0);
    put_rd(32'h20, 32'h0000_0005, 0);
    put_wr(32'h0, 3'd2, 32'h0BAD_F00D, 0);
    go();

`ifdef AHB_SRAM_SLV_ERR_EN
    err_xfer(1'b1, 32'h400, 3'd2, 0);
    err_xfer(1'b0, 32'h2, 3'd2, 0);
    put_rd(32'h0, 32'h0BAD_F00D, 0);
    go();
`else
    put_wr(32'h400, 3'd2, 32'h0000_0077, 0);
    put_rd(32'h0, 32'h0000_0077, 0);
    put_wr(32'h40, 3'd2, 32'h0, 0);
    put_wr(32'h42, 3'd2, 32'h0102_0304, 0);
    put_rd(32'h40, 32'h0102_0304, 0);
    go();
`endif

    sel = 1'b1;
    tick();
    put_wr(32'h0, 3'd2, 32'h600D_CAFE, 3);
    put_rd(32'h0, 32'h600D_CAFE, 3);
    put_wr(32'h8, 3'd2, 32'h1111_1111, 3);
    put_rd(32'h8, 32'h1111_1111, 3);
    put_wr(32'h4, 3'd2, 32'h1234_5678, 3);
    put_rd(32'h8, 32'h1111_1111, 3);
    go();

`ifdef AHB_SRAM_SLV_ERR_EN
    err_xfer(1'b0, 32'h401, 3'd2, 3);
`endif

    m_hsel   = 1'b1;
    m_htrans = 2'd2;
    m_haddr  = 32'h4;
    m_hsize  = 3'd2;
    m_hwrite = 1'b1;
    tick();
    bus_idle();
    m_hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ws_rdy_low", {31'd0, o_rdy}, 32'd0);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy",   {31'd0, o_rdy},  32'd1);
    chk("mid_rst_resp",  {31'd0, o_resp}, 32'd0);
    chk("mid_rst_rdata", o_rdata, 32'h0);
    tick();
    put_rd(32'h4, 32'h1234_5678, 3);
    go();

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Parametrised AHB-Lite slave backed by an internal word-addressed memory.
- Successor to the port-only AHB template: same signal set, plus real behaviour.
- Adds configurable depth, data width, programmable wait states, byte/halfword lane writes, and optional two-cycle ERROR response.
- Sits behind the interconnect decoder as a generic memory/scratchpad target.

Parameters:
ADDR_WIDTH, 32, width of haddr.
DATA_WIDTH, 32, bus width; one of 32 or 64.
DEPTH, 256, memory depth in DATA_WIDTH words; power of two.
WAIT_STATES, 0, wait cycles (hready low) inserted per data phase; 0..15.

Ports:
hclk  input  1  clock; all logic on rising edge.
hreset  input  1  synchronous, active-high reset.
hsel  input  1  slave select from decoder.
haddr  input  ADDR_WIDTH  byte address.
hburst  input  3  burst type; accepted, not used for addressing (master drives every beat address).
hsize  input  3  transfer size (0=byte, 1=half, 2=word, 3=dword).
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
hwdata  input  DATA_WIDTH  write data, valid in data phase.
hwrite  input  1  1=write, 0=read.
hready_in  input  1  bus-level ready; qualifies address phase.
hrdata  output  DATA_WIDTH  read data.
hready  output  1  slave ready / transfer complete.
hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (hreset=1 at clock edge): hready=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Memory contents not reset. Reset mid-transfer abandons the transfer; the pending write is not committed.
- Address phase accepted when hsel & hready_in & htrans[1] at a rising edge. Registered: word index = haddr[log2(DATA_WIDTH/8) +: log2(DEPTH)], byte offset, hsize, hwrite.
- IDLE/BUSY or hsel=0 with hready_in=1: no transfer; slave stays IDLE with hready=1 and hresp=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE, transfer accepted:
  - WAIT_STATES=0: data phase completes next cycle, hready=1.
  - Otherwise: go to WAIT, hready=0 for exactly WAIT_STATES cycles. Last cycle has hready=1 and completes the transfer.
- WAIT: counter decrements each cycle. At 0, hready=1 and the FSM accepts a pipelined next address phase in the same cycle; back-to-back transfers are supported with no bubble.
- Writes: hwdata sampled on the completing data-phase edge. Only byte lanes selected by hsize and byte offset are updated. A hsize exceeding the bus width updates the full word.
- Reads: hrdata driven from memory and valid when hready=1. hrdata holds its last value otherwise.
- Write to X followed immediately by read of X: read returns the newly written data (write-through forwarding).
- hburst is ignored; INCR/WRAP bursts work because each beat carries its own address.

Optional Feature:
- Macro AHB_SRAM_SLV_ERR_EN.
- Defined: ERROR is raised when either condition holds:
  - address is out of range (haddr >= DEPTH*DATA_WIDTH/8);
  - the transfer is unaligned (byte offset not a multiple of 2^hsize) or hsize exceeds the bus width.
- ERROR sequence: after any wait states, ERR1 drives hresp=1, hready=0; then ERR2 drives hresp=1, hready=1; then return to IDLE. An errored write does not modify memory. An errored read returns hrdata=0.
- Not defined: hresp tied 0, no ERR states. Addresses wrap modulo DEPTH words. Misaligned accesses use the lanes implied by hsize and the offset truncated to alignment.

Test Plan:
- WAIT_STATES=0, NONSEQ word write 0xDEADBEEF to 0x10, then read 0x10 -> hready stays 1, hrdata=0xDEADBEEF on the read data-phase cycle.
- WAIT_STATES=3, word read 0x0 -> hready low exactly 3 cycles, high on 4th with correct data.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
- Back-to-back write 0x5 to 0x20 and read 0x20 pipelined -> read returns 0x5, no extra wait cycle.
- AHB_SRAM_SLV_ERR_EN, DEPTH=256, write to 0x400 -> ERR1 (hresp=1, hready=0) then ERR2 (hresp=1, hready=1); memory unchanged. Without macro, same access writes word 0.
- hreset asserted during WAIT of a write -> next cycle hready=1, hresp=0, hrdata=0; target word retains old value.
